// File: rtl/ysyx_23060203_lsu_read_if.sv
// AXI4 read-channel bundle between the LSU load path and the crossbar.
// "out" is the initiator view, "in" the responder view.
interface axi_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 8;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [LEN_W-1:0]  arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [ID_W-1:0]   arid;

    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rlast;
    logic [ID_W-1:0]   rid;
    logic              rready;

    modport out (
        output araddr, arvalid, arlen, arsize, arburst, arid, rready,
        input  arready, rdata, rresp, rvalid, rlast, rid
    );

    modport in (
        input  araddr, arvalid, arlen, arsize, arburst, arid, rready,
        output arready, rdata, rresp, rvalid, rlast, rid
    );
endinterface

// File: rtl/ysyx_23060203_lsu_read.sv
// LSU load initiator: one outstanding single-beat AXI4 read, lane extract and
// sign/zero extension of the returned word; misaligned loads never reach the bus.
module ysyx_23060203_lsu_read #(
    parameter int unsigned AXI_ID = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    axi_if.out          read
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 8;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] BURST_INC = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_RESP
    } state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        signed_q;

    logic              misaligned_c;
    logic [DATA_W-1:0] lane_c;
    logic [DATA_W-1:0] ext_c;
    logic              unused_c;

    // Single-beat, fixed-ID read: only address and size vary per request.
    assign read.arlen   = LEN_W'(0);
    assign read.arburst = BURST_INC;
    assign read.arid    = ID_W'(AXI_ID);

    // Responder-side beat tagging is not needed with one outstanding read.
    assign unused_c = ^{read.rlast, read.rid};

    // Reserved size counts as misaligned so it also short-circuits the bus.
    always_comb begin
        misaligned_c = 1'b0;
        unique case (req_size)
            SIZE_BYTE: misaligned_c = 1'b0;
            SIZE_HALF: misaligned_c = req_addr[0];
            SIZE_WORD: misaligned_c = (req_addr[1:0] != 2'b00);
            default:   misaligned_c = 1'b1;
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend to the full word.
    always_comb begin
        lane_c = read.rdata >> {off_q, 3'b000};
        ext_c  = lane_c;
        unique case (size_q)
            SIZE_BYTE: ext_c = {{24{signed_q & lane_c[7]}}, lane_c[7:0]};
            SIZE_HALF: ext_c = {{16{signed_q & lane_c[15]}}, lane_c[15:0]};
            default:   ext_c = lane_c;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            off_q        <= 2'b00;
            size_q       <= SIZE_BYTE;
            signed_q     <= 1'b0;
            req_ready    <= 1'b1;
            read.arvalid <= 1'b0;
            read.araddr  <= '0;
            read.arsize  <= 3'b000;
            read.rready  <= 1'b0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_err     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        off_q     <= req_addr[1:0];
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        req_ready <= 1'b0;
                        if (misaligned_c) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                        end else begin
                            state        <= S_AR;
                            read.arvalid <= 1'b1;
                            read.araddr  <= req_addr;
                            read.arsize  <= {1'b0, req_size};
                        end
                    end
                end
                S_AR: begin
                    if (read.arready) begin
                        state        <= S_R;
                        read.arvalid <= 1'b0;
                        read.rready  <= 1'b1;
                    end
                end
                S_R: begin
                    if (read.rvalid) begin
                        state       <= S_RESP;
                        read.rready <= 1'b0;
                        resp_valid  <= 1'b1;
                        resp_err    <= (read.rresp != RESP_OKAY);
                        resp_data   <= (read.rresp != RESP_OKAY) ? '0 : ext_c;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060203_lsu_read.sv
// Directed bench for the LSU load initiator: scripted AXI responder, arithmetic
// load model checked every cycle, plus hand-computed literals per load.
module tb_ysyx_23060203_lsu_read;
    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    axi_if bus ();

    ysyx_23060203_lsu_read #(.AXI_ID(0)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .read       (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Responder script and current expectations
    int          ar_wait = 0;
    int          r_wait  = 0;
    bit          r_hold  = 0;
    int          ar_cnt  = 0;
    int          r_cnt   = 0;
    logic [31:0] cur_rdata = '0;
    logic [1:0]  cur_rresp = '0;
    bit          mon_en  = 0;
    logic [31:0] exp_addr = '0;
    logic [1:0]  exp_size = '0;
    bit          exp_mis  = 0;
    logic [31:0] exp_data = '0;
    logic        exp_err  = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    endfunction

    // What a load must return, from the byte-addressing rules alone.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [1:0] sz,
                                          input logic sg, input logic [31:0] rd,
                                          input logic [1:0] rr);
        longint unsigned v;
        longint unsigned mask;
        int nbits;
        if (sz == 2'd3) return {1'b1, 32'h0};
        if ((a % (32'd1 << sz)) != 0) return {1'b1, 32'h0};
        if (rr != 2'b00) return {1'b1, 32'h0};
        nbits = 8 << sz;
        mask  = (64'd1 << nbits) - 64'd1;
        v     = (64'(rd) >> (8 * (a % 4))) & mask;
        if (sg && v[nbits-1]) v = v | ~mask;
        return {1'b0, v[31:0]};
    endfunction

    function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || ((a % (32'd1 << sz)) != 0);
    endfunction

    // Scripted responder: arready/rvalid after a programmable number of wait cycles.
    always @(negedge clock) begin
        if (bus.arvalid) begin
            bus.arready = (ar_cnt >= ar_wait);
            ar_cnt++;
        end else begin
            bus.arready = (ar_wait == 0);
            ar_cnt = 0;
        end
        if (bus.rready) begin
            bus.rvalid = (r_cnt >= r_wait) || r_hold;
            r_cnt++;
        end else begin
            bus.rvalid = r_hold;
            r_cnt = 0;
        end
        bus.rdata = cur_rdata;
        bus.rresp = cur_rresp;
        bus.rlast = 1'b1;
        bus.rid   = 4'd0;
    end

    // Per-cycle compare against the model and the handshake rules.
    always @(negedge clock) begin
        if (mon_en) begin
            chk("req_ready_only_idle", 32'(req_ready),
                32'(!(bus.arvalid || bus.rready || resp_valid)));
            chk("ar_r_exclusive", 32'(bus.arvalid && bus.rready), 32'd0);
            if (exp_mis) chk("no_ar_on_misaligned", 32'(bus.arvalid), 32'd0);
            if (bus.arvalid) begin
                chk("araddr", bus.araddr, exp_addr);
                chk("arsize", 32'(bus.arsize), 32'({1'b0, exp_size}));
                chk("arlen", 32'(bus.arlen), 32'd0);
                chk("arburst", 32'(bus.arburst), 32'd1);
                chk("arid", 32'(bus.arid), 32'd0);
            end
            if (resp_valid) begin
                chk("resp_data_model", resp_data, exp_data);
                chk("resp_err_model", 32'(resp_err), 32'(exp_err));
            end
        end
    end

    task automatic do_load(input string nm, input logic [31:0] a, input logic [1:0] sz,
                           input logic sg, input logic [31:0] rd, input logic [1:0] rr,
                           input int arw, input int rw, input int hold_cycles,
                           input int exp_lat, input logic [31:0] lit_data, input logic lit_err);
        logic [32:0] m;
        int cyc;
        m = model(a, sz, sg, rd, rr);
        exp_addr = a; exp_size = sz; exp_mis = is_mis(a, sz);
        exp_data = m[31:0]; exp_err = m[32];
        ar_wait = arw; r_wait = rw; cur_rdata = rd; cur_rresp = rr;
        chk({nm, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = a; req_size = sz; req_signed = sg;
        @(posedge clock); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk({nm, "_resp_valid"}, 32'(resp_valid), 32'd1);
        if (exp_lat >= 0) chk({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({nm, "_data"}, resp_data, lit_data);
        chk({nm, "_err"}, 32'(resp_err), 32'(lit_err));
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clock); #1;
            chk({nm, "_held_valid"}, 32'(resp_valid), 32'd1);
            chk({nm, "_held_data"}, resp_data, lit_data);
            chk({nm, "_held_err"}, 32'(resp_err), 32'(lit_err));
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        chk({nm, "_resp_drop"}, 32'(resp_valid), 32'd0);
        chk({nm, "_back_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0;
        req_signed = 1'b0; resp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
        chk("rst_rready", 32'(bus.rready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_araddr", bus.araddr, 32'd0);
        reset = 1'b0; mon_en = 1;
        @(posedge clock); #1;

        do_load("word",      32'h0200_0000, 2'd2, 1'b0, 32'h1234_5678, 2'b00, 0, 0, 0, 3, 32'h1234_5678, 1'b0);
        do_load("byte_s",    32'h8000_0003, 2'd0, 1'b1, 32'h80FF_0000, 2'b00, 0, 0, 0, 3, 32'hFFFF_FF80, 1'b0);
        do_load("byte_u",    32'h8000_0003, 2'd0, 1'b0, 32'h80FF_0000, 2'b00, 0, 0, 0, 3, 32'h0000_0080, 1'b0);
        do_load("half_u",    32'h8000_0002, 2'd1, 1'b0, 32'h80FF_0000, 2'b00, 0, 0, 0, 3, 32'h0000_80FF, 1'b0);
        do_load("half_s",    32'h8000_0002, 2'd1, 1'b1, 32'h80FF_0000, 2'b00, 0, 0, 0, 3, 32'hFFFF_80FF, 1'b0);
        do_load("half_mis",  32'h8000_0001, 2'd1, 1'b1, 32'h1111_1111, 2'b00, 0, 0, 0, 1, 32'h0000_0000, 1'b1);
        do_load("word_mis",  32'h8000_0002, 2'd2, 1'b0, 32'h1111_1111, 2'b00, 0, 0, 0, 1, 32'h0000_0000, 1'b1);
        do_load("size3",     32'h8000_0000, 2'd3, 1'b0, 32'h1111_1111, 2'b00, 0, 0, 0, 1, 32'h0000_0000, 1'b1);
        do_load("slv_err",   32'h8000_0010, 2'd2, 1'b0, 32'hCAFE_F00D, 2'b10, 5, 0, 3, -1, 32'h0000_0000, 1'b1);
        do_load("byte1_s",   32'h8000_0001, 2'd0, 1'b1, 32'h0000_7F00, 2'b00, 0, 0, 0, 3, 32'h0000_007F, 1'b0);
        do_load("rvalid_slow", 32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'b00, 0, 4, 1, -1, 32'hDEAD_BEEF, 1'b0);
        r_hold = 1;
        do_load("rvalid_early", 32'h8000_0000, 2'd1, 1'b1, 32'hABCD_8001, 2'b00, 0, 0, 0, 3, 32'hFFFF_8001, 1'b0);
        r_hold = 0;

        // Reset while waiting in the read-data phase with a beat on offer
        exp_addr = 32'h0200_0004; exp_size = 2'd2; exp_mis = 0;
        exp_data = 32'h5555_AAAA; exp_err = 0;
        ar_wait = 0; r_wait = 0; cur_rdata = 32'h5555_AAAA; cur_rresp = 2'b00;
        req_valid = 1'b1; req_addr = 32'h0200_0004; req_size = 2'd2; req_signed = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        chk("rst_mid_in_r", 32'(bus.rready), 32'd1);
        reset = 1'b1; mon_en = 0;
        @(posedge clock); #1;
        chk("rst_mid_rready", 32'(bus.rready), 32'd0);
        chk("rst_mid_arvalid", 32'(bus.arvalid), 32'd0);
        chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        reset = 1'b0; mon_en = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("rst_mid_no_stale", 32'(resp_valid), 32'd0);
        end
        do_load("after_rst", 32'h8000_0002, 2'd1, 1'b0, 32'h7FFF_0000, 2'b00, 0, 0, 0, 3, 32'h0000_7FFF, 1'b0);

        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
